// File: rtl/bcd_down_counter_5digit.sv
// 5-digit packed-BCD countdown counter with run/stop control, tick prescaler and load clamping.
// Optional build macro BCD_WRAP_EN: wrap 00000 -> 99999 with a borrow pulse instead of expiring.
//
// state     | meaning
// ----------+------------------------------------------------
// S_IDLE    | holding count; ticks ignored
// S_RUN     | counting; every TICK_DIV-th tick decrements
// S_EXPIRED | count reached 00000; holding, ticks ignored
module bcd_down_counter_5digit #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [19:0] load_value,
    input  logic        start,
    input  logic        stop,
    input  logic        tick,
    output logic [19:0] count,
    output logic        running,
    output logic        expired,
    output logic        done,
    output logic        borrow,
    output logic        load_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    state_t      r_state;
    logic [19:0] r_count;
    logic [15:0] r_presc;
    logic        r_done;
    logic        r_load_err;

    state_t      w_state_nxt;
    logic [19:0] w_count_nxt;
    logic [15:0] w_presc_nxt;
    logic        w_done_nxt;
    logic        w_load_err_nxt;
    logic [19:0] w_load_clamped;
    logic        w_load_bad;
    logic [19:0] w_count_dec;
    logic        w_count_zero;

    function automatic logic [19:0] f_clamp(input logic [19:0] v);
        logic [19:0] r;
        r = v;
        for (int i = 0; i < 5; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    function automatic logic f_any_bad(input logic [19:0] v);
        logic b;
        b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (v[4*i +: 4] > 4'd9) b = 1'b1;
        end
        return b;
    endfunction

    // Ripple borrow: a zero digit becomes 9 and passes the borrow upward.
    function automatic logic [19:0] f_bcd_dec(input logic [19:0] v);
        logic [19:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign w_load_clamped = f_clamp(load_value);
    assign w_load_bad     = f_any_bad(load_value);
    assign w_count_dec    = f_bcd_dec(r_count);
    assign w_count_zero   = (r_count == 20'h00000);

`ifdef BCD_WRAP_EN
    logic r_borrow;
    logic w_borrow_nxt;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_presc_nxt    = r_presc;
        w_done_nxt     = 1'b0;
        w_load_err_nxt = 1'b0;
`ifdef BCD_WRAP_EN
        w_borrow_nxt   = 1'b0;
`endif
        if (load) begin
            w_state_nxt    = S_IDLE;
            w_count_nxt    = w_load_clamped;
            w_presc_nxt    = '0;
            w_load_err_nxt = w_load_bad;
        end else if (stop) begin
            if (r_state == S_RUN) w_state_nxt = S_IDLE;
        end else if (start) begin
            if (r_state == S_IDLE) begin
`ifdef BCD_WRAP_EN
                w_state_nxt = S_RUN;
                w_presc_nxt = '0;
`else
                if (!w_count_zero) begin
                    w_state_nxt = S_RUN;
                    w_presc_nxt = '0;
                end else begin
                    w_state_nxt = S_EXPIRED;
                    w_done_nxt  = 1'b1;
                end
`endif
            end
        end else if (tick && (r_state == S_RUN)) begin
            if (r_presc == TICK_LAST) begin
                w_presc_nxt = '0;
                w_count_nxt = w_count_dec;
`ifdef BCD_WRAP_EN
                w_borrow_nxt = w_count_zero;
`else
                if (w_count_dec == 20'h00000) begin
                    w_state_nxt = S_EXPIRED;
                    w_done_nxt  = 1'b1;
                end
`endif
            end else begin
                w_presc_nxt = r_presc + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_presc    <= '0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_presc    <= w_presc_nxt;
            r_done     <= w_done_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

`ifdef BCD_WRAP_EN
    always_ff @(posedge clk) begin
        if (rst) r_borrow <= 1'b0;
        else     r_borrow <= w_borrow_nxt;
    end
    assign borrow = r_borrow;
`else
    assign borrow = 1'b0;
`endif

    assign count    = r_count;
    assign running  = (r_state == S_RUN);
    assign expired  = (r_state == S_EXPIRED);
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_down_counter_5digit.sv
// Scoreboard bench for bcd_down_counter_5digit: two instances (TICK_DIV=1 and 4) share stimulus
// and are checked every cycle against an integer-valued reference model.
module tb_bcd_down_counter_5digit;

    logic        clk = 1'b0;
    logic        rst, load, start, stop, tick;
    logic [19:0] load_value;

    logic [19:0] cnt_a, cnt_b;
    logic        run_a, exp_a, done_a, bor_a, lerr_a;
    logic        run_b, exp_b, done_b, bor_b, lerr_b;

    always #5 clk = ~clk;

    bcd_down_counter_5digit #(.TICK_DIV(1)) u_dut_a (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value),
        .start(start), .stop(stop), .tick(tick),
        .count(cnt_a), .running(run_a), .expired(exp_a),
        .done(done_a), .borrow(bor_a), .load_err(lerr_a)
    );

    bcd_down_counter_5digit #(.TICK_DIV(4)) u_dut_b (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value),
        .start(start), .stop(stop), .tick(tick),
        .count(cnt_b), .running(run_b), .expired(exp_b),
        .done(done_b), .borrow(bor_b), .load_err(lerr_b)
    );

    typedef struct packed {
        logic [1:0][19:0] cnt;
        logic [1:0][4:0]  flg;   // {running, expired, done, borrow, load_err}
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef BCD_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    // Reference model: value kept as a plain decimal integer; state 0=idle 1=run 2=expired.
    int m_val[2];
    int m_pre[2];
    int m_st[2];
    bit m_done[2], m_bor[2], m_lerr[2];

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_step(input int k, input bit r, ld, input logic [19:0] lv, input bit sp, st, tk);
        int div;
        int v;
        int dig;
        bit bad;
        div = (k == 0) ? 1 : 4;
        m_done[k] = 0; m_bor[k] = 0; m_lerr[k] = 0;
        if (r) begin
            m_val[k] = 0; m_st[k] = 0; m_pre[k] = 0;
        end else if (ld) begin
            v = 0; bad = 0;
            for (int d = 4; d >= 0; d--) begin
                dig = int'((lv >> (4*d)) & 20'hF);
                if (dig > 9) begin dig = 9; bad = 1; end
                v = v * 10 + dig;
            end
            m_val[k] = v; m_st[k] = 0; m_pre[k] = 0; m_lerr[k] = bad;
        end else if (sp) begin
            if (m_st[k] == 1) m_st[k] = 0;
        end else if (st) begin
            if (m_st[k] == 0) begin
                if (m_val[k] != 0 || WRAP) begin m_st[k] = 1; m_pre[k] = 0; end
                else begin m_st[k] = 2; m_done[k] = 1; end
            end
        end else if (tk && m_st[k] == 1) begin
            if (m_pre[k] == div - 1) begin
                m_pre[k] = 0;
                if (m_val[k] == 0) begin
                    m_val[k] = 99999; m_bor[k] = 1;
                end else begin
                    m_val[k] = m_val[k] - 1;
                    if (m_val[k] == 0 && !WRAP) begin m_st[k] = 2; m_done[k] = 1; end
                end
            end else begin
                m_pre[k] = m_pre[k] + 1;
            end
        end
    endtask

    task automatic step(input bit r, ld, input logic [19:0] lv, input bit sp, st, tk);
        exp_t e;
        rst = r; load = ld; load_value = lv; stop = sp; start = st; tick = tk;
        for (int k = 0; k < 2; k++) begin
            model_step(k, r, ld, lv, sp, st, tk);
            e.cnt[k] = to_bcd(m_val[k]);
            e.flg[k] = {m_st[k] == 1, m_st[k] == 2, m_done[k], m_bor[k], m_lerr[k]};
        end
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 20'h0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 20'h0, 0, 0, 1);
    endtask

    task automatic do_load(input logic [19:0] v);
        step(0, 1, v, 0, 0, 0);
    endtask

    task automatic do_start();
        step(0, 0, 20'h0, 0, 1, 0);
    endtask

    task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: the DUT presents a new output every cycle; pop and compare one entry per edge.
    initial begin
        exp_t  e;
        string fn[5];
        logic [4:0] fa, fb;
        fn[4] = "running"; fn[3] = "expired"; fn[2] = "done"; fn[1] = "borrow"; fn[0] = "load_err";
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                fa = {run_a, exp_a, done_a, bor_a, lerr_a};
                fb = {run_b, exp_b, done_b, bor_b, lerr_b};
                chk("div1 count", cnt_a, e.cnt[0]);
                chk("div4 count", cnt_b, e.cnt[1]);
                for (int i = 0; i < 5; i++) begin
                    chk({"div1 ", fn[i]}, 20'(fa[i]), 20'(e.flg[0][i]));
                    chk({"div4 ", fn[i]}, 20'(fb[i]), 20'(e.flg[1][i]));
                end
            end
        end
    end

    initial begin
        logic [19:0] lv;
        int          p;
        step(1, 0, 20'h0, 0, 0, 0);
        step(1, 0, 20'h0, 0, 0, 0);

        do_load(20'h00003); do_start(); ticks(3); idle(2);
        do_load(20'h10000); do_start(); ticks(1); idle(1);
        do_load(20'h1A3F9); ticks(2); idle(1);
        do_load(20'h00010); do_start(); ticks(8);
        step(0, 0, 20'h0, 1, 0, 0); ticks(5); do_start(); ticks(4);
        step(0, 0, 20'h0, 1, 0, 1); idle(1);
        do_load(20'h00005); do_start(); ticks(1);
        step(0, 1, 20'h00042, 0, 0, 1); idle(1);
        do_start(); ticks(2);
        step(1, 0, 20'h0, 0, 0, 0); idle(1);
        do_load(20'h00000); do_start(); ticks(2);
        do_load(20'hFFFFF); idle(1);
        do_load(20'h00001); do_start(); ticks(6); idle(1);

        for (int c = 0; c < 4000; c++) begin
            p = $urandom_range(0, 99);
            if ($urandom_range(0, 1) == 0) lv = to_bcd($urandom_range(0, 12));
            else                           lv = 20'($urandom);
            step(p == 0,
                 $urandom_range(0, 99) < 4, lv,
                 $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 60);
        end
        idle(2);

        repeat (4) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
